// File: rtl/vend_payout_controller.sv
// Payout controller for a vending machine: runs one item spiral or the change hopper at a time,
// queues vend and nickel requests, and latches a sticky fault when a sensor pulse never arrives.
module vend_payout_controller #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       dispense,
  input  logic [3:0] item_number,
  input  logic       nickel_out,
  input  logic       drop_sensed,
  input  logic       coin_sensed,
  output logic       spiral_en,
  output logic [3:0] spiral_select,
  output logic       hopper_on,
  output logic [3:0] pending_nickels,
  output logic       busy,
  output logic       fault,
  output logic       overflow
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, VEND, PAY, FAULT} state_t;

  state_t          state, state_nxt;
  logic            vend_pending, vend_pending_nxt;
  logic [3:0]      pending_nxt;
  logic [3:0]      select_nxt;
  logic            overflow_nxt;
  logic [TW-1:0]   timer, timer_nxt;
  logic            coin_ok, drop_ok, timed_out, active;

  always_comb begin
    active           = (state == VEND) || (state == PAY);
    coin_ok          = coin_sensed && (state == PAY);
    drop_ok          = drop_sensed && (state == VEND);
    overflow_nxt     = overflow;
    select_nxt       = spiral_select;
    vend_pending_nxt = vend_pending;
    pending_nxt      = pending_nickels;

    // Only one vend can be outstanding; a second request is lost and flagged.
    if (dispense) begin
      if (vend_pending) begin
        overflow_nxt = 1'b1;
      end else begin
        vend_pending_nxt = 1'b1;
        select_nxt       = item_number;
      end
    end
    if (drop_ok) begin
      vend_pending_nxt = 1'b0;
    end

    // A nickel request and a paid coin on the same edge cancel out.
    if (nickel_out && !coin_ok) begin
      if (pending_nickels == 4'hF) begin
        overflow_nxt = 1'b1;
      end else begin
        pending_nxt = pending_nickels + 4'd1;
      end
    end else if (coin_ok && !nickel_out && (pending_nickels != 4'd0)) begin
      pending_nxt = pending_nickels - 4'd1;
    end

    timed_out = active && !(drop_ok || coin_ok) && (timer == TW'(TIMEOUT_CYCLES - 1));

    state_nxt = state;
    case (state)
      IDLE: begin
        if (vend_pending) begin
          state_nxt = VEND;
        end else if (pending_nickels != 4'd0) begin
          state_nxt = PAY;
        end
      end
      VEND: begin
        if (drop_ok) begin
          state_nxt = (pending_nxt != 4'd0) ? PAY : IDLE;
        end else if (timed_out) begin
          state_nxt = FAULT;
        end
      end
      PAY: begin
        if (coin_ok && (pending_nxt == 4'd0)) begin
          state_nxt = vend_pending ? VEND : IDLE;
        end else if (timed_out) begin
          state_nxt = FAULT;
        end
      end
      FAULT: state_nxt = FAULT;
      default: state_nxt = IDLE;
    endcase

    // Any progress from a sensor, or a change of state, restarts the watchdog.
    if ((state_nxt != state) || drop_ok || coin_ok || !active) begin
      timer_nxt = '0;
    end else begin
      timer_nxt = timer + 1'b1;
    end
  end

  // Motor drives are registered from the next state so they track it exactly and never overlap.
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      spiral_en       <= 1'b0;
      hopper_on       <= 1'b0;
      spiral_select   <= 4'd0;
      pending_nickels <= 4'd0;
      vend_pending    <= 1'b0;
      fault           <= 1'b0;
      overflow        <= 1'b0;
      timer           <= '0;
    end else begin
      state           <= state_nxt;
      spiral_en       <= (state_nxt == VEND);
      hopper_on       <= (state_nxt == PAY);
      spiral_select   <= select_nxt;
      pending_nickels <= pending_nxt;
      vend_pending    <= vend_pending_nxt;
      fault           <= (state_nxt == FAULT);
      overflow        <= overflow_nxt;
      timer           <= timer_nxt;
    end
  end

  assign busy = (state != IDLE) || vend_pending || (pending_nickels != 4'd0);

endmodule

// File: tb/tb_vend_payout_controller.sv
// Directed bench for vend_payout_controller: stimulus queues expected output snapshots,
// a negedge monitor pops and compares them on the cycle they fall due.
module tb_vend_payout_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       dispense = 1'b0;
  logic [3:0] item_number = 4'd0;
  logic       nickel_out = 1'b0;
  logic       drop_sensed = 1'b0;
  logic       coin_sensed = 1'b0;
  logic       spiral_en, hopper_on, busy, fault, overflow;
  logic [3:0] spiral_select, pending_nickels;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int          cyc;
    string       name;
    logic [12:0] vec;
  } exp_t;

  exp_t sb[$];

  vend_payout_controller #(.TIMEOUT_CYCLES(8)) dut (
    .clock(clock),
    .reset(reset),
    .dispense(dispense),
    .item_number(item_number),
    .nickel_out(nickel_out),
    .drop_sensed(drop_sensed),
    .coin_sensed(coin_sensed),
    .spiral_en(spiral_en),
    .spiral_select(spiral_select),
    .hopper_on(hopper_on),
    .pending_nickels(pending_nickels),
    .busy(busy),
    .fault(fault),
    .overflow(overflow)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Entries are due after the edge whose count matches; anything older was missed.
  always @(negedge clock) begin
    exp_t        e;
    logic [12:0] got;
    got = {spiral_en, spiral_select, hopper_on, pending_nickels, busy, fault, overflow};
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.cyc < cyc) begin
        errors++;
        $display("[TB] FAIL %s: check due at cycle %0d not reached until %0d", e.name, e.cyc, cyc);
      end else if (got !== e.vec) begin
        errors++;
        $display("[TB] FAIL %s: got se=%0b sel=%0d ho=%0b pn=%0d busy=%0b fault=%0b ovf=%0b, expected se=%0b sel=%0d ho=%0b pn=%0d busy=%0b fault=%0b ovf=%0b",
                 e.name, got[12], got[11:8], got[7], got[6:3], got[2], got[1], got[0],
                 e.vec[12], e.vec[11:8], e.vec[7], e.vec[6:3], e.vec[2], e.vec[1], e.vec[0]);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic d, input logic [3:0] item, input logic nk,
                               input logic drop, input logic coin, input logic rst);
    dispense    = d;
    item_number = item;
    nickel_out  = nk;
    drop_sensed = drop;
    coin_sensed = coin;
    reset       = rst;
    tick(1);
    dispense    = 1'b0;
    item_number = 4'd0;
    nickel_out  = 1'b0;
    drop_sensed = 1'b0;
    coin_sensed = 1'b0;
    reset       = 1'b0;
  endtask

  task automatic checkOutput(input int dly, input string name, input logic se, input logic [3:0] sel,
                             input logic ho, input logic [3:0] pn, input logic bz, input logic ft,
                             input logic ov);
    exp_t e;
    int   i;
    e.cyc  = cyc + dly;
    e.name = name;
    e.vec  = {se, sel, ho, pn, bz, ft, ov};
    i = 0;
    while (i < sb.size() && sb[i].cyc <= e.cyc) i++;
    sb.insert(i, e);
  endtask

  task automatic doReset(input string name);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput(0, name, 0, 4'd0, 0, 4'd0, 0, 0, 0);
  endtask

  initial begin
    doReset("reset_init");

    // Plain vend of slot 4.
    applyStimulus(1, 4'd4, 0, 0, 0, 0);
    checkOutput(0, "vend_latch", 0, 4'd4, 0, 4'd0, 1, 0, 0);
    checkOutput(1, "vend_motor_on", 1, 4'd4, 0, 4'd0, 1, 0, 0);
    tick(2);
    applyStimulus(0, 4'd0, 0, 1, 0, 0);
    checkOutput(0, "vend_drop_idle", 0, 4'd4, 0, 4'd0, 0, 0, 0);

    // Vend plus one nickel requested together: vend first, then change.
    applyStimulus(1, 4'd4, 1, 0, 0, 0);
    checkOutput(0, "combo_latch", 0, 4'd4, 0, 4'd1, 1, 0, 0);
    checkOutput(1, "combo_vend_first", 1, 4'd4, 0, 4'd1, 1, 0, 0);
    tick(1);
    applyStimulus(0, 4'd0, 0, 1, 0, 0);
    checkOutput(0, "combo_drop_to_pay", 0, 4'd4, 1, 4'd1, 1, 0, 0);
    tick(1);
    applyStimulus(0, 4'd0, 0, 0, 1, 0);
    checkOutput(0, "combo_coin_done", 0, 4'd4, 0, 4'd0, 0, 0, 0);

    // Three nickels, each paid three cycles after its request.
    applyStimulus(0, 4'd0, 1, 0, 0, 0);
    checkOutput(0, "pay3_n1", 0, 4'd4, 0, 4'd1, 1, 0, 0);
    applyStimulus(0, 4'd0, 1, 0, 0, 0);
    checkOutput(0, "pay3_n2", 0, 4'd4, 1, 4'd2, 1, 0, 0);
    applyStimulus(0, 4'd0, 1, 0, 0, 0);
    checkOutput(0, "pay3_n3", 0, 4'd4, 1, 4'd3, 1, 0, 0);
    applyStimulus(0, 4'd0, 0, 0, 1, 0);
    checkOutput(0, "pay3_c1", 0, 4'd4, 1, 4'd2, 1, 0, 0);
    applyStimulus(0, 4'd0, 0, 0, 1, 0);
    checkOutput(0, "pay3_c2", 0, 4'd4, 1, 4'd1, 1, 0, 0);
    applyStimulus(0, 4'd0, 0, 0, 1, 0);
    checkOutput(0, "pay3_c3", 0, 4'd4, 0, 4'd0, 0, 0, 0);

    // Sixteen nickels with no coins: hopper times out after 8 cycles, count saturates.
    doReset("reset_before_sat");
    for (int k = 0; k < 16; k++) begin
      applyStimulus(0, 4'd0, 1, 0, 0, 0);
      if (k == 8) checkOutput(0, "sat_last_pay", 0, 4'd0, 1, 4'd9, 1, 0, 0);
      if (k == 9) checkOutput(0, "sat_pay_timeout", 0, 4'd0, 0, 4'd10, 1, 1, 0);
      if (k == 14) checkOutput(0, "sat_reach15", 0, 4'd0, 0, 4'd15, 1, 1, 0);
      if (k == 15) checkOutput(0, "sat_overflow", 0, 4'd0, 0, 4'd15, 1, 1, 1);
    end

    // Second dispense while vending is dropped.
    doReset("reset_before_dup");
    applyStimulus(1, 4'd3, 0, 0, 0, 0);
    tick(1);
    applyStimulus(1, 4'd9, 0, 0, 0, 0);
    checkOutput(0, "dup_dropped", 1, 4'd3, 0, 4'd0, 1, 0, 1);
    applyStimulus(0, 4'd0, 0, 1, 0, 0);
    checkOutput(0, "dup_done_sticky", 0, 4'd3, 0, 4'd0, 0, 0, 1);

    // Vend with no drop: fault after 8 spiral cycles, later requests recorded only.
    doReset("reset_before_fault");
    applyStimulus(1, 4'd7, 0, 0, 0, 0);
    checkOutput(8, "fault_last_vend", 1, 4'd7, 0, 4'd0, 1, 0, 0);
    checkOutput(9, "fault_vend_timeout", 0, 4'd7, 0, 4'd0, 1, 1, 0);
    tick(9);
    applyStimulus(0, 4'd0, 1, 0, 0, 0);
    checkOutput(0, "fault_nickel_recorded", 0, 4'd7, 0, 4'd1, 1, 1, 0);
    checkOutput(3, "fault_hopper_stays_off", 0, 4'd7, 0, 4'd1, 1, 1, 0);
    tick(3);
    doReset("reset_clears_fault");

    // Reset during PAY with two nickels pending, with coincident requests ignored.
    applyStimulus(0, 4'd0, 1, 0, 0, 0);
    applyStimulus(0, 4'd0, 1, 0, 0, 0);
    checkOutput(0, "mid_pay_two", 0, 4'd0, 1, 4'd2, 1, 0, 0);
    applyStimulus(1, 4'd5, 1, 0, 0, 1);
    checkOutput(0, "mid_pay_reset", 0, 4'd0, 0, 4'd0, 0, 0, 0);
    checkOutput(1, "after_reset_quiet", 0, 4'd0, 0, 4'd0, 0, 0, 0);

    tick(3);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
